// File: rtl/mips_cpu_harvard.sv
// mips_cpu_harvard: single-cycle MIPS I subset CPU with Harvard buses and branch delay slots.
// Define MIPS_CPU_LINK_BRANCH_EN to add BLTZAL/BGEZAL.
module mips_cpu_harvard #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);
    logic [31:0] regs [32];
    logic [31:0] pc, target, next_pc, pc4, instr, rs_v, rt_v, imm_s, imm_z, load_val;
    logic [31:0] br_target, wb_val;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, wb_reg;
    logic        pending, take, wb_en, run;

    // Buses are little-endian; internally everything is big-endian words.
    assign instr          = {instr_readdata[7:0], instr_readdata[15:8], instr_readdata[23:16], instr_readdata[31:24]};
    assign load_val       = {data_readdata[7:0], data_readdata[15:8], data_readdata[23:16], data_readdata[31:24]};
    assign op             = instr[31:26];
    assign rs             = instr[25:21];
    assign rt             = instr[20:16];
    assign rd             = instr[15:11];
    assign shamt          = instr[10:6];
    assign funct          = instr[5:0];
    assign rs_v           = regs[rs];
    assign rt_v           = regs[rt];
    assign imm_s          = {{16{instr[15]}}, instr[15:0]};
    assign imm_z          = {16'd0, instr[15:0]};
    assign pc4            = pc + 32'd4;
    assign next_pc        = pending ? target : pc4;
    assign run            = reset & active & clk_enable;
    assign instr_address  = pc;
    assign register_v0    = regs[2];
    assign data_address   = rs_v + imm_s;
    assign data_write     = run && op == 6'h2B;
    assign data_read      = run && op == 6'h23;
    assign data_writedata = {rt_v[7:0], rt_v[15:8], rt_v[23:16], rt_v[31:24]};

    always_comb begin
        take      = 1'b0;
        wb_en     = 1'b0;
        wb_reg    = (op == 6'h00) ? rd : rt;
        wb_val    = 32'd0;
        br_target = pc4 + {imm_s[29:0], 2'b00};
        case (op)
            6'h00: begin
                wb_en = 1'b1;
                case (funct)
                    6'h21: wb_val = rs_v + rt_v;
                    6'h23: wb_val = rs_v - rt_v;
                    6'h24: wb_val = rs_v & rt_v;
                    6'h25: wb_val = rs_v | rt_v;
                    6'h26: wb_val = rs_v ^ rt_v;
                    6'h27: wb_val = ~(rs_v | rt_v);
                    6'h2A: wb_val = {31'd0, $signed(rs_v) < $signed(rt_v)};
                    6'h2B: wb_val = {31'd0, rs_v < rt_v};
                    6'h00: wb_val = rt_v << shamt;
                    6'h02: wb_val = rt_v >> shamt;
                    6'h03: wb_val = $signed(rt_v) >>> shamt;
                    6'h04: wb_val = rt_v << rs_v[4:0];
                    6'h06: wb_val = rt_v >> rs_v[4:0];
                    6'h07: wb_val = $signed(rt_v) >>> rs_v[4:0];
                    6'h08: begin wb_en = 1'b0; take = 1'b1; br_target = rs_v; end
                    6'h09: begin take = 1'b1; br_target = rs_v; wb_val = pc4 + 32'd4; end
                    default: wb_en = 1'b0;
                endcase
            end
            6'h01: begin
`ifdef MIPS_CPU_LINK_BRANCH_EN
                if (rt[3:1] == 3'b000) begin
                    take = rs_v[31] ^ rt[0];
                    if (rt[4]) begin wb_en = 1'b1; wb_reg = 5'd31; wb_val = pc4 + 32'd4; end
                end
`else
                if (rt[4:1] == 4'b0000) take = rs_v[31] ^ rt[0];
`endif
            end
            6'h02: begin take = 1'b1; br_target = {pc4[31:28], instr[25:0], 2'b00}; end
            6'h03: begin
                take = 1'b1;
                br_target = {pc4[31:28], instr[25:0], 2'b00};
                wb_en = 1'b1;
                wb_reg = 5'd31;
                wb_val = pc4 + 32'd4;
            end
            6'h04: take = rs_v == rt_v;
            6'h05: take = rs_v != rt_v;
            6'h06: take = $signed(rs_v) <= 32'sd0;
            6'h07: take = $signed(rs_v) > 32'sd0;
            6'h09: begin wb_en = 1'b1; wb_val = rs_v + imm_s; end
            6'h0A: begin wb_en = 1'b1; wb_val = {31'd0, $signed(rs_v) < $signed(imm_s)}; end
            6'h0B: begin wb_en = 1'b1; wb_val = {31'd0, rs_v < imm_s}; end
            6'h0C: begin wb_en = 1'b1; wb_val = rs_v & imm_z; end
            6'h0D: begin wb_en = 1'b1; wb_val = rs_v | imm_z; end
            6'h0E: begin wb_en = 1'b1; wb_val = rs_v ^ imm_z; end
            6'h0F: begin wb_en = 1'b1; wb_val = {instr[15:0], 16'd0}; end
            6'h23: begin wb_en = 1'b1; wb_val = load_val; end
            default: ;
        endcase
    end

    // A taken branch only arms the target; the delay slot at pc+4 runs first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_VECTOR;
            active  <= 1'b1;
            pending <= 1'b0;
            target  <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (clk_enable && active) begin
            pc      <= next_pc;
            active  <= next_pc != 32'd0;
            pending <= take;
            if (take) target <= br_target;
            if (wb_en && wb_reg != 5'd0) regs[wb_reg] <= wb_val;
        end
    end
endmodule

// File: tb/tb_mips_cpu_harvard.sv
// tb_mips_cpu_harvard: lockstep instruction-set model against the CPU, directed and random programs.
module tb_mips_cpu_harvard;
    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk = 1'b0, reset = 1'b1, clk_enable = 1'b1;
    logic        active, data_write, data_read;
    logic [31:0] register_v0, instr_address, instr_readdata, data_address, data_writedata, data_readdata;
    logic [31:0] rom [256];
    logic [31:0] d_mem [1024];
    logic [31:0] m_regs [32];
    logic [31:0] m_mem [1024];
    logic [31:0] m_pc, m_npc, last_waddr;
    logic        m_active;
    int          checks = 0, errors = 0, n = 0, ce_mode = 0, n_writes = 0;

    mips_cpu_harvard dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .clk_enable(clk_enable), .instr_address(instr_address), .instr_readdata(instr_readdata),
        .data_address(data_address), .data_write(data_write), .data_read(data_read),
        .data_writedata(data_writedata), .data_readdata(data_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] swap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] rom_at(input logic [31:0] a);
        return (a[31:10] == BASE[31:10]) ? rom[a[9:2]] : 32'd0;
    endfunction

    assign instr_readdata = (instr_address[31:10] == BASE[31:10]) ? swap(rom[instr_address[9:2]]) : 32'd0;
    assign data_readdata  = d_mem[data_address[11:2]];
    always @(posedge clk) if (data_write) d_mem[data_address[11:2]] <= data_writedata;

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh);
        return {6'h00, s, t, d, sh, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] o, input logic [31:0] a);
        return {o, a[27:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'd0;
        n = 0;
    endtask
    task automatic put(input logic [31:0] w);
        rom[n] = w;
        n++;
    endtask

    task automatic model_reset();
        m_pc = BASE;
        m_npc = BASE + 32'd4;
        m_active = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    // Architectural PC/nPC interpreter: a jump rewrites nPC, so the slot after it still runs.
    task automatic model_step();
        logic [31:0] w, a, b, se, ze, tgt, res, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        logic        taken;
        int          wr, sa;
        w = rom_at(m_pc);
        op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6]; fn = w[5:0];
        a = m_regs[rs]; b = m_regs[rt]; sa = a;
        se = {{16{w[15]}}, w[15:0]}; ze = {16'd0, w[15:0]};
        ea = a + se;
        tgt = m_pc + 4 + se * 4;
        taken = 1'b0; wr = 0; res = 0;
        case (op)
            6'h00: case (fn)
                6'h21: begin wr = rd; res = a + b; end
                6'h23: begin wr = rd; res = a - b; end
                6'h24: begin wr = rd; res = a & b; end
                6'h25: begin wr = rd; res = a | b; end
                6'h26: begin wr = rd; res = a ^ b; end
                6'h27: begin wr = rd; res = ~(a | b); end
                6'h2A: begin wr = rd; res = (sa < int'(b)) ? 1 : 0; end
                6'h2B: begin wr = rd; res = (a < b) ? 1 : 0; end
                6'h00: begin wr = rd; res = b << sh; end
                6'h02: begin wr = rd; res = b >> sh; end
                6'h03: begin wr = rd; res = int'(b) >>> sh; end
                6'h04: begin wr = rd; res = b << (a % 32); end
                6'h06: begin wr = rd; res = b >> (a % 32); end
                6'h07: begin wr = rd; res = int'(b) >>> (a % 32); end
                6'h08: begin taken = 1; tgt = a; end
                6'h09: begin taken = 1; tgt = a; wr = rd; res = m_pc + 8; end
                default: ;
            endcase
            6'h01: begin
                if (rt == 0) taken = sa < 0;
                if (rt == 1) taken = sa >= 0;
`ifdef MIPS_CPU_LINK_BRANCH_EN
                if (rt == 16) begin taken = sa < 0; wr = 31; res = m_pc + 8; end
                if (rt == 17) begin taken = sa >= 0; wr = 31; res = m_pc + 8; end
`endif
            end
            6'h02: begin taken = 1; tgt = {m_pc[31:28] + ((m_pc + 4) >> 28 != m_pc >> 28 ? 4'd1 : 4'd0), w[25:0], 2'b00}; end
            6'h03: begin taken = 1; tgt = {m_pc[31:28] + ((m_pc + 4) >> 28 != m_pc >> 28 ? 4'd1 : 4'd0), w[25:0], 2'b00}; wr = 31; res = m_pc + 8; end
            6'h04: taken = a == b;
            6'h05: taken = a != b;
            6'h06: taken = sa <= 0;
            6'h07: taken = sa > 0;
            6'h09: begin wr = rt; res = a + se; end
            6'h0A: begin wr = rt; res = (sa < int'(se)) ? 1 : 0; end
            6'h0B: begin wr = rt; res = (a < se) ? 1 : 0; end
            6'h0C: begin wr = rt; res = a & ze; end
            6'h0D: begin wr = rt; res = a | ze; end
            6'h0E: begin wr = rt; res = a ^ ze; end
            6'h0F: begin wr = rt; res = ze << 16; end
            6'h23: begin wr = rt; res = m_mem[ea[11:2]]; end
            6'h2B: m_mem[ea[11:2]] = b;
            default: ;
        endcase
        m_pc = m_npc;
        m_npc = taken ? tgt : m_npc + 4;
        if (wr != 0) m_regs[wr] = res;
        if (m_pc == 0) m_active = 1'b0;
    endtask

    task automatic tick(input int cyc);
        logic [31:0] w, ea;
        logic        exp_sw, exp_lw;
        clk_enable = (ce_mode == 1) ? ($urandom_range(0, 3) != 0) : (ce_mode == 2) ? !(cyc >= 3 && cyc < 8) : 1'b1;
        #1;
        w = rom_at(m_pc);
        ea = m_regs[w[25:21]] + {{16{w[15]}}, w[15:0]};
        exp_sw = m_active && clk_enable && w[31:26] == 6'h2B;
        exp_lw = m_active && clk_enable && w[31:26] == 6'h23;
        check("pc", instr_address, m_pc);
        check("v0", register_v0, m_regs[2]);
        check("active", {31'd0, active}, {31'd0, m_active});
        check("dwrite", {31'd0, data_write}, {31'd0, exp_sw});
        check("dread", {31'd0, data_read}, {31'd0, exp_lw});
        if (exp_sw || exp_lw) check("daddr", data_address, ea);
        if (exp_sw) begin
            check("wdata", data_writedata, swap(m_regs[w[20:16]]));
            n_writes++;
            last_waddr = data_address;
        end
        @(posedge clk);
        if (clk_enable && m_active) model_step();
        @(negedge clk);
    endtask

    task automatic start();
        reset = 1'b0;
        clk_enable = 1'b1;
        n_writes = 0;
        model_reset();
        #1;
        check("rst_pc", instr_address, BASE);
        check("rst_v0", register_v0, 32'd0);
        check("rst_active", {31'd0, active}, 32'd1);
        check("rst_dwrite", {31'd0, data_write}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run();
        int cyc = 0;
        while (m_active && cyc < 3000) begin
            tick(cyc);
            cyc++;
        end
        check("halted", {31'd0, m_active}, 32'd0);
        for (int i = 0; i < 3; i++) tick(cyc + i);
    endtask

    task automatic load_jump_blez();
        clear_rom();
        put(enc_j(6'h02, BASE + 32'h10));
        put(enc_i(6'h09, 1, 1, 16'hFFFE));
        put(enc_r(6'h08, 0, 0, 0, 0));
        put(enc_i(6'h09, 0, 2, 16'd2));
        put(enc_i(6'h06, 1, 0, 16'hFFFD));
        put(32'd0);
    endtask

    task automatic load_mem_roundtrip();
        clear_rom();
        put(enc_i(6'h09, 0, 4, 16'h1000));
        put(enc_i(6'h0F, 0, 3, 16'h1234));
        put(enc_i(6'h0D, 3, 3, 16'h5678));
        put(enc_i(6'h2B, 4, 3, 16'd0));
        put(enc_i(6'h23, 4, 2, 16'd0));
        put(enc_r(6'h08, 0, 0, 0, 0));
        put(32'd0);
    endtask

    task automatic gen_random();
        logic [5:0] rfn [14] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
        logic [5:0] ifn [7]  = '{6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F};
        logic [4:0] rim [4]  = '{5'd0, 5'd1, 5'd16, 5'd17};
        int k;
        clear_rom();
        for (int r = 1; r < 8; r++) begin
            put(enc_i(6'h0F, 0, 5'(r), 16'($urandom)));
            put(enc_i(6'h0D, 5'(r), 5'(r), 16'($urandom)));
        end
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 99);
            if (k < 50)
                put(enc_r(rfn[$urandom_range(0, 13)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom)));
            else if (k < 75)
                put(enc_i(ifn[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)));
            else if (k < 83)
                put(enc_i(($urandom_range(0, 1) != 0) ? 6'h2B : 6'h23, 0, 5'($urandom_range(0, 7)), 16'($urandom_range(0, 15) * 4)));
            else if (k < 95) begin
                k = $urandom_range(0, 7);
                if (k < 4) put(enc_i(6'(4 + k), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom_range(0, 3))));
                else put(enc_i(6'h01, 5'($urandom_range(0, 7)), rim[k - 4], 16'($urandom_range(0, 3))));
            end else
                put({6'h3F, 26'($urandom)});
        end
        for (int r = 1; r < 8; r++) put(enc_i(6'h2B, 0, 5'(r), 16'(256 + 4 * r)));
        put(enc_r(6'h08, 0, 0, 0, 0));
        put(32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            d_mem[i] = 32'd0;
            m_mem[i] = 32'd0;
        end
        @(negedge clk);

        load_jump_blez();
        start();
        run();
        check("t1_v0", register_v0, 32'd2);
        check("t1_r1", dut.regs[1], 32'hFFFFFFFE);
        check("t1_active", {31'd0, active}, 32'd0);

        clear_rom();
        put(enc_i(6'h09, 0, 1, 16'hFFFB));
        put(enc_i(6'h07, 1, 0, 16'd10));
        put(enc_i(6'h09, 0, 2, 16'd7));
        put(enc_i(6'h09, 2, 2, 16'd1));
        put(enc_r(6'h08, 0, 0, 0, 0));
        put(32'd0);
        start();
        run();
        check("t2_v0", register_v0, 32'd8);

        load_mem_roundtrip();
        start();
        run();
        check("t3_v0", register_v0, 32'h12345678);
        check("t3_nwrites", n_writes, 32'd1);
        check("t3_waddr", last_waddr, 32'h1000);

        ce_mode = 2;
        start();
        run();
        ce_mode = 0;
        check("t4_v0", register_v0, 32'h12345678);

        clear_rom();
        put(enc_j(6'h03, BASE + 32'h10));
        put(32'd0);
        put(enc_r(6'h08, 0, 0, 0, 0));
        put(32'd0);
        put(enc_i(6'h09, 0, 2, 16'd3));
        put(enc_r(6'h08, 31, 0, 0, 0));
        put(32'd0);
        start();
        run();
        check("t5_r31", dut.regs[31], BASE + 32'd8);
        check("t5_v0", register_v0, 32'd3);

        clear_rom();
        put(enc_i(6'h09, 0, 2, 16'd9));
        put(enc_j(6'h02, BASE + 32'h14));
        put(enc_i(6'h09, 2, 2, 16'd1));
        put(enc_r(6'h08, 0, 0, 0, 0));
        put(32'd0);
        put(enc_r(6'h08, 0, 0, 0, 0));
        put(32'd0);
        start();
        tick(0);
        tick(1);
        #2 reset = 1'b0;
        #1;
        check("arst_pc", instr_address, BASE);
        check("arst_v0", register_v0, 32'd0);
        check("arst_active", {31'd0, active}, 32'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        run();
        check("t6_v0", register_v0, 32'd10);

        for (int p = 0; p < 25; p++) begin
            gen_random();
            ce_mode = p % 2;
            start();
            run();
        end
        ce_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
